// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared state encoding and width helper for the parametrised FIFO
package param_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        WR_ERR    = 3'd2,
        READ      = 3'd3,
        RD_ERR    = 3'd4,
        RDWR      = 3'd5,
        RD_ERR_WR = 3'd6,
        WR_ERR_RD = 3'd7
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_read_mux.sv
// fifo_read_mux: combinational DEPTH-to-1 select of the storage word at the head pointer
module fifo_read_mux
    import param_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PW = clog2(DEPTH)
) (
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [PW-1:0]    sel,
    output logic [WIDTH-1:0] data
);

    // Explicit compare per entry keeps non-power-of-2 depths from indexing past the array
    always_comb begin
        data = '0;
        for (int i = 0; i < DEPTH; i++)
            data = (sel == PW'(i)) ? mem[i] : data;
    end

endmodule

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with registered read data, ack/err handshake and level flags
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 2,
    localparam int PW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    data_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    state_t           state, nxt;
    logic             wr_ok, rd_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb
        nxt = (!wr_en && !rd_en) ? IDLE :
              (!rd_en)           ? (full  ? WR_ERR : WRITE) :
              (!wr_en)           ? (empty ? RD_ERR : READ)  :
              empty              ? RD_ERR_WR :
              full               ? WR_ERR_RD : RDWR;

    fifo_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
        .mem  (mem),
        .sel  (head),
        .data (rd_data)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            d_out <= '0;
        end else begin
            state <= nxt;
            count <= count + CW'(wr_ok) - CW'(rd_ok);
            if (wr_ok) tail <= inc(tail);
            if (rd_ok) begin
                head  <= inc(head);
                d_out <= rd_data;
            end
        end

    // Storage is deliberately left unreset; validity is tracked by count alone
    always_ff @(posedge clk)
        if (wr_ok) mem[tail] <= d_in;

    assign wr_ack = state inside {WRITE, RDWR, RD_ERR_WR};
    assign wr_err = state inside {WR_ERR, WR_ERR_RD};
    assign rd_ack = state inside {READ, RDWR, WR_ERR_RD};
    assign rd_err = state inside {RD_ERR, RD_ERR_WR};

    assign data_count   = count;
    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AFULL_LVL);
    assign almost_empty = count <= CW'(AEMPTY_LVL);

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: scoreboard bench for an 8-deep and a 5-deep param_fifo sharing clock and reset
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] d_in = '0;
    logic        wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [31:0] dout0, dout1;
    logic        wa0, we0, ra0, re0, fu0, em0, af0, ae0;
    logic        wa1, we1, ra1, re1, fu1, em1, af1, ae1;
    logic [3:0]  dc0;
    logic [2:0]  dc1;

    int          vectors = 0, miscompares = 0;
    logic [31:0] q0[$], q1[$];
    int          cnt [2];
    logic [31:0] exp_d [2];
    logic [3:0]  exp_s [2];

    always #5 clk = ~clk;

    param_fifo #(.WIDTH(32), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2)) u8 (
        .clk(clk), .reset(reset), .wr_en(wr0), .rd_en(rd0), .d_in(d_in), .d_out(dout0),
        .wr_ack(wa0), .wr_err(we0), .rd_ack(ra0), .rd_err(re0), .full(fu0), .empty(em0),
        .almost_full(af0), .almost_empty(ae0), .data_count(dc0)
    );

    param_fifo #(.WIDTH(32), .DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1)) u5 (
        .clk(clk), .reset(reset), .wr_en(wr1), .rd_en(rd1), .d_in(d_in), .d_out(dout1),
        .wr_ack(wa1), .wr_err(we1), .rd_ack(ra1), .rd_err(re1), .full(fu1), .empty(em1),
        .almost_full(af1), .almost_empty(ae1), .data_count(dc1)
    );

    function automatic int dep(input int u);  return u ? 5 : 8; endfunction
    function automatic int afl(input int u);  return u ? 4 : 6; endfunction
    function automatic int ael(input int u);  return u ? 1 : 2; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_unit(input int u, input string tag);
        logic [31:0] d;
        logic [3:0]  s, f, ef;
        int          c;
        d  = u ? dout1 : dout0;
        s  = u ? {wa1, we1, ra1, re1} : {wa0, we0, ra0, re0};
        f  = u ? {fu1, em1, af1, ae1} : {fu0, em0, af0, ae0};
        c  = u ? int'(dc1) : int'(dc0);
        ef = {cnt[u] == dep(u), cnt[u] == 0, cnt[u] >= afl(u), cnt[u] <= ael(u)};
        chk({tag, "/d_out"}, d, exp_d[u]);
        chk({tag, "/wack_werr_rack_rerr"}, 32'(s), 32'(exp_s[u]));
        chk({tag, "/full_empty_af_ae"}, 32'(f), 32'(ef));
        chk({tag, "/data_count"}, 32'(c), 32'(cnt[u]));
    endtask

    task automatic op(input int u, input logic w, input logic r, input logic [31:0] d, input string tag);
        bit wa, we, ra, re;
        wa = w && cnt[u] < dep(u);
        we = w && !wa;
        ra = r && cnt[u] > 0;
        re = r && !ra;
        if (u == 0) begin wr0 = w; rd0 = r; end
        else begin wr1 = w; rd1 = r; end
        d_in = d;
        if (ra) exp_d[u] = (u == 0) ? q0.pop_front() : q1.pop_front();
        if (wa) begin
            if (u == 0) q0.push_back(d);
            else q1.push_back(d);
        end
        cnt[u] += int'(wa) - int'(ra);
        exp_s[u] = {wa, we, ra, re};
        exp_s[1 - u] = '0;
        @(posedge clk);
        #1;
        wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
        chk_unit(u, tag);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        cnt   = '{0, 0};
        exp_d = '{32'h0, 32'h0};
        exp_s = '{4'h0, 4'h0};
    endtask

    initial begin
        model_reset();
        #1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        op(0, 0, 0, 0, "idle_a");
        op(0, 0, 0, 0, "idle_b");
        op(1, 0, 0, 0, "idle_d5");

        for (int i = 1; i <= 8; i++) op(0, 1, 0, 32'h11 * i, "fill");
        op(0, 1, 0, 32'h99, "wr_when_full");
        for (int i = 1; i <= 8; i++) op(0, 0, 1, 0, "drain");
        op(0, 0, 1, 0, "rd_when_empty");

        for (int i = 0; i < 5; i++) op(0, 1, 0, 32'hA0 + i, "wrap_w5");
        for (int i = 0; i < 5; i++) op(0, 0, 1, 0, "wrap_r5");
        for (int i = 0; i < 8; i++) op(0, 1, 0, 32'hB0 + i, "wrap_w8");
        for (int i = 0; i < 8; i++) op(0, 0, 1, 0, "wrap_r8");

        op(0, 1, 1, 32'hC0, "rw_empty");
        for (int i = 1; i < 8; i++) op(0, 1, 0, 32'hC0 + i, "refill");
        op(0, 1, 1, 32'hCF, "rw_full");
        for (int i = 0; i < 4; i++) op(0, 0, 1, 0, "to_three");
        op(0, 1, 1, 32'hD3, "rw_mid");
        op(0, 1, 1, 32'hD4, "rw_mid2");
        op(0, 1, 0, 32'hD5, "to_four");

        wr0 = 1'b1;
        d_in = 32'hDEAD_BEEF;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_unit(0, "async_rst8");
        chk_unit(1, "async_rst5");
        @(posedge clk);
        #1;
        wr0 = 1'b0;
        reset = 1'b0;
        op(0, 0, 1, 0, "rd_after_rst");

        for (int i = 0; i < 3; i++) op(1, 1, 0, 32'hE0 + i, "d5_w3");
        for (int i = 0; i < 3; i++) op(1, 0, 1, 0, "d5_r3");
        for (int i = 0; i < 5; i++) op(1, 1, 0, 32'hF0 + i, "d5_w5");
        op(1, 1, 0, 32'hFF, "d5_wr_full");
        op(1, 1, 1, 32'hFE, "d5_rw_full");
        for (int i = 0; i < 4; i++) op(1, 1, 1, 32'h70 + i, "d5_rw_stream");
        for (int i = 0; i < 5; i++) op(1, 0, 1, 0, "d5_r5");
        op(1, 0, 1, 0, "d5_rd_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
